core_request_responder: RTL and testbench

CORE_REQUEST_RESPONDER -- requirements
Module: core_request_responder

---
 rtl/cache_pkg.sv | 29 ++
 rtl/msi_line_fsm.sv | 38 +++
 rtl/core_request_responder.sv | 183 ++++++++++++++++++
 tb/tb_core_request_responder.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and widths for the core request responder.
//   ADDR_W / DATA_W : core word address and data widths
//   msi_t           : per-line coherence state (I, S, M)
//   ctrl_state_t    : miss-handling controller state
//   snoop_kind_t    : qualified snoop seen by one line
package cache_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    MSI_I = 2'd0,
    MSI_S = 2'd1,
    MSI_M = 2'd2
  } msi_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FILL      = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    SNOOP_NONE = 2'd0,
    SNOOP_RD   = 2'd1,
    SNOOP_WR   = 2'd2
  } snoop_kind_t;

endpackage

// File: rtl/msi_line_fsm.sv
// Next-state logic for the MSI state of one cache line.
// Ports:
//   cur         in  : current MSI state of the line
//   fill        in  : line is being installed from memory this cycle
//   local_hit   in  : core request completes on this line this cycle
//   local_write in  : that core request is a store
//   snoop       in  : snoop already qualified as matching this line
//   nxt         out : MSI state for the next cycle
//   flush       out : line must supply its modified data to the snooper
import cache_pkg::*;

module msi_line_fsm (
  input  msi_t        cur,
  input  logic        fill,
  input  logic        local_hit,
  input  logic        local_write,
  input  snoop_kind_t snoop,
  output msi_t        nxt,
  output logic        flush
);

  always_comb begin
    nxt   = cur;
    flush = 1'b0;
    if (snoop == SNOOP_RD && cur == MSI_M) begin
      nxt   = MSI_S;
      flush = 1'b1;
    end else if (snoop == SNOOP_WR && cur != MSI_I) begin
      nxt   = MSI_I;
      flush = (cur == MSI_M);
    end
    // A local store cannot coincide with a snoop on the same line (the core
    // is stalled on index conflicts), so ordering here only matters for fill.
    if (local_hit && local_write) nxt = MSI_M;
    if (fill)                     nxt = MSI_S;
  end

endmodule

// File: rtl/core_request_responder.sv
// Direct-mapped, write-back, MSI-coherent line store sitting between a core
// and memory. Hits complete in the request cycle; misses optionally write the
// modified victim back, then fill the line and let the request complete as a
// hit. Bus snoops downgrade/invalidate lines and flush modified data.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   read, write, address, write_data core request (write wins if both)
//   fetched_data, stall             load result, request-not-done
//   mem_req, mem_we, mem_addr, mem_wdata, mem_ack, mem_rdata  memory port
//   snoop_valid, snoop_we, snoop_addr  observed remote bus accesses
//   bus_inv, bus_addr               invalidate broadcast on S->M upgrade
//   flush_valid, flush_data         modified data supplied to a snooper
//   hit_count, miss_count           saturating statistics, only when the
//                                   RESPONDER_STATS_EN macro is defined
//
// Controller states:
//   state        | meaning
//   ST_IDLE      | serving hits, detecting misses
//   ST_WRITEBACK | writing modified victim to memory, waiting mem_ack
//   ST_FILL      | reading requested word from memory, waiting mem_ack
import cache_pkg::*;

module core_request_responder #(
  parameter int LINES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] fetched_data,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              snoop_valid,
  input  logic              snoop_we,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              bus_inv,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              flush_valid,
  output logic [DATA_W-1:0] flush_data
`ifdef RESPONDER_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  msi_t              msi_q  [LINES];
  msi_t              msi_nxt[LINES];
  snoop_kind_t       snoop_kind[LINES];
  logic [LINES-1:0]  flush_vec;

  ctrl_state_t state_q;

  logic [IDX_W-1:0] req_idx, snoop_idx;
  logic [TAG_W-1:0] req_tag, snoop_tag;
  logic req, line_hit, snoop_hit, snoop_ignore, conflict;
  logic complete_hit, wr_hit, miss_start, victim_wb, fill_done;

  assign req_idx   = address[IDX_W-1:0];
  assign req_tag   = address[ADDR_W-1:IDX_W];
  assign snoop_idx = snoop_addr[IDX_W-1:0];
  assign snoop_tag = snoop_addr[ADDR_W-1:IDX_W];

  assign req       = read | write;
  assign line_hit  = req && (msi_q[req_idx] != MSI_I) && (tag_q[req_idx] == req_tag);
  assign snoop_hit = snoop_valid && (msi_q[snoop_idx] != MSI_I) && (tag_q[snoop_idx] == snoop_tag);
  // During FILL the slot is being reallocated (any dirty victim is already
  // in memory), so snoops to that index are dropped.
  assign snoop_ignore = (state_q == ST_FILL) && (snoop_idx == req_idx);
  assign conflict     = snoop_valid && req && (snoop_idx == req_idx);

  assign complete_hit = (state_q == ST_IDLE) && line_hit && !conflict;
  assign wr_hit       = complete_hit && write;
  assign miss_start   = (state_q == ST_IDLE) && req && !line_hit && !conflict;
  // A valid line with the requested tag would have hit, so M alone means
  // the victim belongs to a different address.
  assign victim_wb    = (msi_q[req_idx] == MSI_M);
  assign fill_done    = (state_q == ST_FILL) && mem_ack;

  assign stall    = (state_q != ST_IDLE) || (req && !line_hit) || conflict;
  assign bus_inv  = wr_hit && (msi_q[req_idx] == MSI_S);
  assign bus_addr = bus_inv ? address : '0;

  for (genvar g = 0; g < LINES; g++) begin : g_line
    assign snoop_kind[g] = (snoop_hit && !snoop_ignore && (snoop_idx == IDX_W'(g)))
                           ? (snoop_we ? SNOOP_WR : SNOOP_RD) : SNOOP_NONE;

    msi_line_fsm u_msi (
      .cur        (msi_q[g]),
      .fill       (fill_done && (req_idx == IDX_W'(g))),
      .local_hit  (wr_hit && (req_idx == IDX_W'(g))),
      .local_write(write),
      .snoop      (snoop_kind[g]),
      .nxt        (msi_nxt[g]),
      .flush      (flush_vec[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fetched_data <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      flush_valid  <= 1'b0;
      flush_data   <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
        msi_q[i]  <= MSI_I;
      end
    end else begin
      flush_valid <= |flush_vec;
      if (|flush_vec) flush_data <= data_q[snoop_idx];
      for (int i = 0; i < LINES; i++) msi_q[i] <= msi_nxt[i];

      case (state_q)
        ST_IDLE: begin
          if (complete_hit) begin
            if (write) data_q[req_idx] <= write_data;
            else       fetched_data    <= data_q[req_idx];
          end else if (miss_start) begin
            mem_req <= 1'b1;
            if (victim_wb) begin
              state_q   <= ST_WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= {tag_q[req_idx], req_idx};
              mem_wdata <= data_q[req_idx];
            end else begin
              state_q  <= ST_FILL;
              mem_we   <= 1'b0;
              mem_addr <= address;
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack) begin
            state_q  <= ST_FILL;
            mem_we   <= 1'b0;
            mem_addr <= address;
          end
        end
        ST_FILL: begin
          if (mem_ack) begin
            state_q         <= ST_IDLE;
            mem_req         <= 1'b0;
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= mem_rdata;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (complete_hit && hit_count != 16'hFFFF) hit_count  <= hit_count + 16'd1;
      if (miss_start && miss_count != 16'hFFFF)  miss_count <= miss_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_request_responder.sv
module tb_core_request_responder;

  localparam int LINES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read = 1'b0, write = 1'b0;
  logic [8:0]  address = '0;
  logic [15:0] write_data = '0;
  logic [15:0] fetched_data;
  logic        stall;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        snoop_valid = 1'b0, snoop_we = 1'b0;
  logic [8:0]  snoop_addr = '0;
  logic        bus_inv;
  logic [8:0]  bus_addr;
  logic        flush_valid;
  logic [15:0] flush_data;

  logic        resp_ack = 1'b0;
  logic [15:0] resp_rdata = '0;
  logic        stray_ack = 1'b0;
  int          lat = 1;

  assign mem_ack   = resp_ack | stray_ack;
  assign mem_rdata = stray_ack ? 16'hDEAD : resp_rdata;

  core_request_responder #(.LINES(LINES)) dut (
    .clk(clk), .rst_n(rst_n),
    .read(read), .write(write), .address(address), .write_data(write_data),
    .fetched_data(fetched_data), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .snoop_valid(snoop_valid), .snoop_we(snoop_we), .snoop_addr(snoop_addr),
    .bus_inv(bus_inv), .bus_addr(bus_addr),
    .flush_valid(flush_valid), .flush_data(flush_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic        we;
    logic [8:0]  addr;
    logic [15:0] data;
  } mem_op_t;

  mem_op_t     mem_q[$];
  logic [15:0] exp_q[$];
  logic [8:0]  inv_q[$];
  logic [15:0] flush_q[$];

  int          m_st  [LINES];   // 0 invalid, 1 shared, 2 modified
  logic [8:0]  m_addr[LINES];
  logic [15:0] m_data[LINES];
  logic [15:0] model_mem[512];
  logic [15:0] last_fetch;

  function automatic logic [15:0] mem_init(input logic [8:0] a);
    logic [15:0] p;
    if (a == 9'h005) return 16'h1234;
    p = {7'd0, a} * 16'd40503;
    return p ^ 16'h5A5A;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) m_st[i] = 0;
    exp_q.delete();
    last_fetch = '0;
  endfunction

  function automatic void model_access(input bit wr, input logic [8:0] a, input logic [15:0] d);
    int i;
    i = int'(a) % LINES;
    if (!(m_st[i] != 0 && m_addr[i] == a)) begin
      if (m_st[i] == 2) begin
        mem_q.push_back('{1'b1, m_addr[i], m_data[i]});
        model_mem[m_addr[i]] = m_data[i];
      end
      mem_q.push_back('{1'b0, a, 16'h0});
      m_addr[i] = a;
      m_data[i] = model_mem[a];
      m_st[i]   = 1;
    end
    if (wr) begin
      if (m_st[i] == 1) inv_q.push_back(a);
      m_st[i]   = 2;
      m_data[i] = d;
    end else begin
      last_fetch = m_data[i];
    end
    exp_q.push_back(last_fetch);
  endfunction

  function automatic void model_snoop(input bit we, input logic [8:0] a);
    int i;
    i = int'(a) % LINES;
    if (m_st[i] != 0 && m_addr[i] == a) begin
      if (m_st[i] == 2) flush_q.push_back(m_data[i]);
      if (we)               m_st[i] = 0;
      else if (m_st[i] == 2) m_st[i] = 1;
    end
  endfunction

  // ---------------- memory responder + memory-side checking ----------------
  logic [15:0] mem_arr[512];
  bit          mem_init_done = 1'b0;
  int          resp_cnt = 0;
  int          cur_lat = 1;
  mem_op_t     op;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (!mem_init_done) begin
        for (int k = 0; k < 512; k++) mem_arr[k] = mem_init(9'(k));
        mem_init_done = 1'b1;
      end
      resp_cnt = 0;
      resp_ack = 1'b0;
    end else if (resp_ack) begin
      resp_ack = 1'b0;
      resp_cnt = 0;
    end else if (mem_req) begin
      if (resp_cnt == 0) begin
        cur_lat = lat;
        if (mem_q.size() == 0) chk("mem_req_unexpected", mem_req, 0);
        else begin
          op = mem_q.pop_front();
          chk("mem_we", mem_we, op.we);
          chk("mem_addr", mem_addr, op.addr);
          if (op.we) chk("mem_wdata", mem_wdata, op.data);
        end
      end
      resp_cnt++;
      if (resp_cnt >= cur_lat) begin
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
        else        resp_rdata = mem_arr[mem_addr];
        resp_ack = 1'b1;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_inv) begin
        if (inv_q.size() == 0) chk("bus_inv_unexpected", bus_inv, 0);
        else chk("bus_addr", bus_addr, inv_q.pop_front());
      end
      if (flush_valid) begin
        if (flush_q.size() == 0) chk("flush_unexpected", flush_valid, 0);
        else chk("flush_data", flush_data, flush_q.pop_front());
      end
    end
  end

  logic [15:0] mon_exp;
  initial forever begin
    @(negedge clk);
    if (rst_n && (read || write) && !stall) begin
      if (exp_q.size() == 0) chk("completion_unexpected", exp_q.size(), 1);
      else begin
        mon_exp = exp_q.pop_front();
        @(posedge clk);
        #1;
        chk("fetched_data", fetched_data, mon_exp);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input bit wr, input logic [8:0] a, input logic [15:0] d,
                        input bit sv, input bit swe, input logic [8:0] sa, input int s_at,
                        output int stalls);
    bit done;
    // A snoop issued later than the first cycle lands in WRITEBACK/FILL; the
    // only such use here targets the slot being filled, which is dropped.
    if (sv && s_at == 0) model_snoop(swe, sa);
    model_access(wr, a, d);
    read = !wr; write = wr; address = a; write_data = d;
    stalls = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      snoop_valid = sv && (c == s_at);
      snoop_we    = swe;
      snoop_addr  = sa;
      @(negedge clk);
      if (!stall) done = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
    end
    snoop_valid = 1'b0;
    read = 1'b0; write = 1'b0;
    if (!done) chk("request_timeout", done, 1);
  endtask

  task automatic do_snoop(input bit we, input logic [8:0] a);
    model_snoop(we, a);
    snoop_valid = 1'b1; snoop_we = we; snoop_addr = a;
    @(posedge clk);
    #1;
    snoop_valid = 1'b0;
  endtask

  function automatic logic [8:0] pick_addr();
    int tg;
    case ($urandom_range(0, 3))
      0: tg = 0;
      1: tg = 1;
      2: tg = 2;
      default: tg = 7'h41;
    endcase
    return 9'(tg * LINES + int'($urandom_range(0, LINES - 1)));
  endfunction

  int st;
  logic [8:0] ra, sa;

  initial begin
    for (int k = 0; k < 512; k++) model_mem[k] = mem_init(9'(k));
    for (int i = 0; i < LINES; i++) begin
      m_addr[i] = '0; m_data[i] = '0;
    end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("reset_fetched_data", fetched_data, 0);
    chk("reset_stall", stall, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_bus_inv", bus_inv, 0);
    chk("reset_flush_valid", flush_valid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // cold read, memory answers after 3 cycles
    lat = 3;
    do_req(0, 9'h005, 16'h0, 0, 0, 9'h0, 0, st);
    chk("cold_read_stalls", st, 4);
    chk("cold_read_data", fetched_data, 16'h1234);
    // repeat read hits
    do_req(0, 9'h005, 16'h0, 0, 0, 9'h0, 0, st);
    chk("hit_read_stalls", st, 0);
    // write on shared line upgrades with invalidate
    do_req(1, 9'h005, 16'hBEEF, 0, 0, 9'h0, 0, st);
    chk("upgrade_write_stalls", st, 0);
    // same index, new tag: writeback of dirty victim then fill
    lat = 2;
    do_req(0, 9'h009, 16'h0, 0, 0, 9'h0, 0, st);
    chk("victim_miss_stalled", st > 2, 1);
    // dirty line answers snoop read with flush, snoop write invalidates
    do_req(1, 9'h009, 16'hC0DE, 0, 0, 9'h0, 0, st);
    do_snoop(0, 9'h009);
    do_snoop(1, 9'h009);
    @(posedge clk);
    #1;
    do_req(0, 9'h009, 16'h0, 0, 0, 9'h0, 0, st);
    chk("post_invalidate_miss", st > 0, 1);
    // snoop to same index in the request cycle stalls exactly one cycle
    do_req(0, 9'h009, 16'h0, 1, 0, 9'h00D, 0, st);
    chk("conflict_stalls", st, 1);
    // snoop of the dirty victim while its slot is in FILL is dropped
    do_req(1, 9'h009, 16'h7777, 0, 0, 9'h0, 0, st);
    lat = 2;
    do_req(0, 9'h011, 16'h0, 1, 0, 9'h009, 4, st);
    do_req(0, 9'h011, 16'h0, 0, 0, 9'h0, 0, st);
    chk("fill_snoop_ignored_hit", st, 0);

    // reset in the middle of a fill
    lat = 10;
    model_access(0, 9'h0A2, 16'h0);
    read = 1'b1; address = 9'h0A2;
    repeat (3) @(posedge clk);
    #1;
    chk("fill_pending_mem_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_mem_req", mem_req, 0);
    chk("reset_clears_fetched", fetched_data, 0);
    read = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    stray_ack = 1'b1;
    @(posedge clk);
    #1;
    stray_ack = 1'b0;
    chk("late_ack_mem_req", mem_req, 0);
    chk("late_ack_stall", stall, 0);
    chk("late_ack_fetched", fetched_data, 0);
    lat = 1;
    do_req(0, 9'h011, 16'h0, 0, 0, 9'h0, 0, st);
    chk("post_reset_line_invalid", st > 0, 1);

    // randomized traffic
    for (int n = 0; n < 250; n++) begin
      int r;
      r   = int'($urandom_range(0, 99));
      lat = int'($urandom_range(1, 4));
      ra  = pick_addr();
      if (r < 60) begin
        do_req(r < 25, ra, 16'($urandom), 0, 0, 9'h0, 0, st);
      end else if (r < 70) begin
        sa = pick_addr();
        sa[1:0] = ra[1:0];
        do_req(r < 65, ra, 16'($urandom), 1, $urandom_range(0, 1) == 1, sa, 0, st);
      end else if (r < 92) begin
        do_snoop($urandom_range(0, 1) == 1, ra);
      end else begin
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        stray_ack = 1'b0;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("mem_q_drained", mem_q.size(), 0);
    chk("inv_q_drained", inv_q.size(), 0);
    chk("flush_q_drained", flush_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
